// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: one-MAC-per-cycle 2-D convolution streaming saturated results in raster order
module conv2d_stream_engine #(
  parameter int SIZE = 7,
  parameter int SIZEKer = 3,
  parameter int WIDTH_BIT = 8,
  parameter int STRIDE = 1,
  parameter int FRAC_SHIFT = 0,
  parameter int ACC_W = 2*WIDTH_BIT+$clog2(SIZEKer*SIZEKer)+1,
  localparam int OUT_SIZE = (SIZE-SIZEKer)/STRIDE+1,
  localparam int RW = $clog2(OUT_SIZE)+1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic relu_en,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] inpMatrixI,
  input  logic [SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] Kernel,
  input  logic [WIDTH_BIT-1:0] bias,
  output logic busy,
  output logic done,
  output logic out_valid,
  input  logic out_ready,
  output logic [WIDTH_BIT-1:0] out_data,
  output logic [RW-1:0] out_row,
  output logic [RW-1:0] out_col,
  output logic out_last
);
  localparam int KW = SIZEKer > 1 ? $clog2(SIZEKer) : 1;
  localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
  if (SIZEKer > SIZE) begin : g_bad_kernel
    $error("SIZEKer must not exceed SIZE");
  end
  typedef enum logic [1:0] {IDLE, MAC, POST, OUT} state_t;
  state_t state, state_nx;
  logic [KW-1:0] ky, kx;
  logic [RW-1:0] row, col;
  logic [IW-1:0] pr, pc;
  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [ACC_W-1:0] acc, sum, sh, rl;
  logic [WIDTH_BIT-1:0] sat;
  logic relu_q, kx_end, tap_last, col_end, last_pos, hs;
  always_comb begin
    pr = IW'(row) * IW'(STRIDE) + IW'(ky);
    pc = IW'(col) * IW'(STRIDE) + IW'(kx);
    prod = $signed(inpMatrixI[pr][pc]) * $signed(Kernel[ky][kx]);
    sum = acc + ACC_W'($signed(bias));
    sh = sum >>> FRAC_SHIFT;
    rl = (relu_q && sh < 0) ? '0 : sh;
    // in range only when every bit above the output sign bit matches it
    sat = (&rl[ACC_W-1:WIDTH_BIT-1] || ~|rl[ACC_W-1:WIDTH_BIT-1]) ? rl[WIDTH_BIT-1:0]
        : {rl[ACC_W-1], {(WIDTH_BIT-1){~rl[ACC_W-1]}}};
    kx_end = kx == KW'(SIZEKer-1);
    tap_last = kx_end && ky == KW'(SIZEKer-1);
    col_end = col == RW'(OUT_SIZE-1);
    last_pos = col_end && row == RW'(OUT_SIZE-1);
    hs = out_valid && out_ready;
    state_nx = state == IDLE ? (start ? MAC : IDLE)
             : state == MAC  ? (tap_last ? POST : MAC)
             : state == POST ? OUT
             : hs ? (out_last ? IDLE : MAC) : OUT;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      ky <= '0;
      kx <= '0;
      row <= '0;
      col <= '0;
      relu_q <= 1'b0;
      done <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_row <= '0;
      out_col <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          ky <= '0;
          kx <= '0;
          row <= '0;
          col <= '0;
          relu_q <= relu_en;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          kx <= kx_end ? '0 : kx + 1'b1;
          if (kx_end) ky <= tap_last ? '0 : ky + 1'b1;
        end
        POST: begin
          out_data <= sat;
          out_row <= row;
          out_col <= col;
          out_last <= last_pos;
          out_valid <= 1'b1;
        end
        OUT: if (hs) begin
          out_valid <= 1'b0;
          done <= out_last;
          acc <= '0;
          ky <= '0;
          kx <= '0;
          if (!out_last) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine: table-driven frames plus hand sequences, scoreboard-checked outputs
module tb_conv2d_stream_engine;
  logic clock = 0, reset = 1, relu, rdy;
  logic st[3];
  logic [6:0][6:0][7:0] inp;
  logic [2:0][2:0][7:0] ker;
  logic [7:0] bias;
  logic bs[3], dn[3], ov[3], olast[3];
  logic [7:0] od[3];
  logic [3:0] orow[3], ocol[3];
  logic [3:0] row0, col0, row1, col1;
  logic [2:0] row2, col2;
  assign orow[0] = row0;
  assign ocol[0] = col0;
  assign orow[1] = row1;
  assign ocol[1] = col1;
  assign orow[2] = {1'b0, row2};
  assign ocol[2] = {1'b0, col2};

  conv2d_stream_engine u0 (.clock(clock), .reset(reset), .start(st[0]), .relu_en(relu),
    .inpMatrixI(inp), .Kernel(ker), .bias(bias), .busy(bs[0]), .done(dn[0]),
    .out_valid(ov[0]), .out_ready(rdy), .out_data(od[0]), .out_row(row0), .out_col(col0),
    .out_last(olast[0]));
  conv2d_stream_engine #(.FRAC_SHIFT(4)) u1 (.clock(clock), .reset(reset), .start(st[1]),
    .relu_en(relu), .inpMatrixI(inp), .Kernel(ker), .bias(bias), .busy(bs[1]), .done(dn[1]),
    .out_valid(ov[1]), .out_ready(rdy), .out_data(od[1]), .out_row(row1), .out_col(col1),
    .out_last(olast[1]));
  conv2d_stream_engine #(.STRIDE(2)) u2 (.clock(clock), .reset(reset), .start(st[2]),
    .relu_en(relu), .inpMatrixI(inp), .Kernel(ker), .bias(bias), .busy(bs[2]), .done(dn[2]),
    .out_valid(ov[2]), .out_ready(rdy), .out_data(od[2]), .out_row(row2), .out_col(col2),
    .out_last(olast[2]));

  always #5 clock = ~clock;

  typedef struct {logic [7:0] d; int r; int c; bit last;} exp_t;
  typedef struct {int sel; int iv; int kv; int b; bit relu; int exp;} vec_t;
  exp_t q[$];
  vec_t tbl[6];
  int checks = 0, failures = 0, sel = 0, done_cnt = 0, cyc = 0, t0 = 0, first_v = 0;
  bit seen_v = 0, hold_v = 0;
  logic [7:0] hd;
  logic [3:0] hr, hc;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    exp_t e;
    if (hold_v) begin
      checks++;
      if (!ov[sel] || od[sel] !== hd || orow[sel] !== hr || ocol[sel] !== hc) begin
        failures++;
        $display("FAIL hold_stable got v=%0b d=%0d r=%0d c=%0d exp v=1 d=%0d r=%0d c=%0d",
          ov[sel], $signed(od[sel]), orow[sel], ocol[sel], $signed(hd), hr, hc);
      end
    end
    if (ov[sel] && rdy) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL extra_output got d=%0d r=%0d c=%0d exp none", $signed(od[sel]), orow[sel], ocol[sel]);
      end else begin
        e = q.pop_front();
        if (od[sel] !== e.d || orow[sel] != 4'(e.r) || ocol[sel] != 4'(e.c) || olast[sel] !== e.last) begin
          failures++;
          $display("FAIL output got d=%0d r=%0d c=%0d last=%0b exp d=%0d r=%0d c=%0d last=%0b",
            $signed(od[sel]), orow[sel], ocol[sel], olast[sel], $signed(e.d), e.r, e.c, e.last);
        end
      end
    end
    if (dn[sel]) begin
      done_cnt++;
      checks++;
      if (ov[sel]) begin
        failures++;
        $display("FAIL done_with_valid got valid=1 exp valid=0");
      end
    end
    if (ov[sel] && !seen_v) begin
      seen_v = 1;
      first_v = cyc;
    end
    hold_v = ov[sel] && !rdy;
    hd = od[sel];
    hr = orow[sel];
    hc = ocol[sel];
  end

  task automatic fill(int iv, int kv);
    for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) inp[r][c] = 8'(iv);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ker[r][c] = 8'(kv);
  endtask

  task automatic push_uniform(int n, int v);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) q.push_back('{8'(v), r, c, (r == n-1 && c == n-1)});
  endtask

  task automatic kick(int s);
    sel = s;
    done_cnt = 0;
    seen_v = 0;
    st[s] = 1;
    @(posedge clock);
    #1 st[s] = 0;
    t0 = cyc;
  endtask

  task automatic wait_frame(int budget);
    int n = 0;
    while ((q.size() != 0 || done_cnt == 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0 || done_cnt != 1 || bs[sel]) begin
      failures++;
      $display("FAIL frame_end got left=%0d dones=%0d busy=%0b exp left=0 dones=1 busy=0",
        q.size(), done_cnt, bs[sel]);
    end
  endtask

  task automatic wait_q(int n, int budget);
    int k = 0;
    while (q.size() > n && k < budget) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (q.size() != n) begin
      failures++;
      $display("FAIL wait_queue got left=%0d exp left=%0d", q.size(), n);
    end
  endtask

  task automatic check_zero(string tag, int s);
    checks++;
    if (bs[s] || dn[s] || ov[s] || olast[s] || od[s] != 0 || orow[s] != 0 || ocol[s] != 0) begin
      failures++;
      $display("FAIL %s got busy=%0b done=%0b v=%0b last=%0b d=%0d r=%0d c=%0d exp all 0",
        tag, bs[s], dn[s], ov[s], olast[s], od[s], orow[s], ocol[s]);
    end
  endtask

  initial begin
    int sv[9];
    int k;
    sv = '{8, 10, 12, 22, 24, 26, 36, 38, 40};
    tbl[0] = '{0, 1, 1, 0, 1, 9};
    tbl[1] = '{0, 1, -1, 2, 1, 0};
    tbl[2] = '{0, 1, -1, 2, 0, -7};
    tbl[3] = '{0, 127, 127, 0, 1, 127};
    tbl[4] = '{0, -128, 127, 0, 0, -128};
    tbl[5] = '{1, 1, 16, 0, 1, 9};
    for (int s = 0; s < 3; s++) st[s] = 0;
    rdy = 1;
    relu = 1;
    bias = 0;
    inp = '0;
    ker = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 3; s++) check_zero("reset_state", s);
    reset = 0;
    foreach (tbl[i]) begin
      fill(tbl[i].iv, tbl[i].kv);
      bias = 8'(tbl[i].b);
      relu = tbl[i].relu;
      push_uniform(5, tbl[i].exp);
      kick(tbl[i].sel);
      wait_frame(600);
      if (i == 0) begin
        checks++;
        if (first_v - t0 != 10) begin
          failures++;
          $display("FAIL first_valid got=%0d exp=10", first_v - t0);
        end
      end
    end
    // backpressure on the third output with a stray start while busy
    fill(1, 1);
    bias = 0;
    relu = 1;
    push_uniform(5, 9);
    kick(0);
    wait_q(23, 100);
    @(posedge clock);
    #1 rdy = 0;
    k = 0;
    while (!ov[0] && k < 30) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (!ov[0]) begin
      failures++;
      $display("FAIL stall_valid got=0 exp=1");
    end
    repeat (2) @(posedge clock);
    #1 st[0] = 1;
    @(posedge clock);
    #1 st[0] = 0;
    repeat (3) @(posedge clock);
    #1 rdy = 1;
    wait_frame(600);
    // stride 2 on a ramp image with a centre-tap kernel
    for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) inp[r][c] = 8'(r*7 + c);
    ker = '0;
    ker[1][1] = 8'd1;
    for (int i = 0; i < 9; i++) q.push_back('{8'(sv[i]), i/3, i%3, (i == 8)});
    kick(2);
    wait_frame(400);
    // reset mid-frame after the fourth handshake, then restart
    fill(1, 1);
    push_uniform(5, 9);
    kick(0);
    wait_q(21, 200);
    @(posedge clock);
    #1 reset = 1;
    @(posedge clock);
    #1 check_zero("mid_reset", 0);
    reset = 0;
    q.delete();
    done_cnt = 0;
    repeat (15) @(negedge clock);
    checks++;
    if (done_cnt != 0 || ov[0]) begin
      failures++;
      $display("FAIL abort got dones=%0d v=%0b exp dones=0 v=0", done_cnt, ov[0]);
    end
    push_uniform(5, 9);
    kick(0);
    wait_frame(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
